seg_scan_mux: RTL and testbench

Parametrised time-multiplexed seven-segment display driver. It is the next-generation replacement for the fixed 4-digit scanner.
- Drives DIGITS common-anode/cathode digits from a packed hex bus.
- Adds per-digit enable, PWM brightness and tear-free frame snapshotting.
- Sits between the core's debug/status outputs (register readback, sr) and the board's an/segment pins.

---
 rtl/seg_pkg.sv | 38 +++
 rtl/seg_hex_decoder.sv | 21 ++
 rtl/seg_scan_mux.sv | 151 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared segment constants and hex-to-segment table for seg_scan_mux
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  typedef logic [6:0] seg7_t;  // {a,b,c,d,e,f,g}, active-high

  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;

  localparam logic [7:0] ALL_OFF = 8'h00;
  localparam logic [7:0] ALL_ON  = 8'hFF;

  // Entry 15 first so HEX_SEG[n] selects the glyph for nibble n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

  function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_hex_decoder.sv
// ============================================================================
// Module   : seg_hex_decoder
// Purpose  : Combinational 4-bit nibble to active-high 7-segment decode
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = hex_to_seg(nibble);
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_mux.sv
// ============================================================================
// Module   : seg_scan_mux
// Purpose  : Time-multiplexed 7-segment scanner with per-digit enable, PWM
//            dimming and frame snapshotting. Optional leading-zero blanking
//            when SEG_SCAN_LEADING_ZERO_BLANK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_mux
  import seg_pkg::*;
#(
  parameter  int DIGITS     = 4,
  parameter  int PRESCALE_W = 17,
  parameter  int DIM_W      = 3,
  parameter  int ACTIVE_LOW = 1,
  localparam int CUR_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIM_W-1:0]      brightness,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            pattern,
  output logic [CUR_W-1:0]      cur_digit,
  output logic                  frame_tick
);

  localparam logic [CUR_W-1:0]  LAST_DIGIT = CUR_W'(DIGITS - 1);
  localparam logic              POL_LOW    = (ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_MASK    = {DIGITS{POL_LOW}};
  localparam logic [7:0]        PAT_MASK   = POL_LOW ? ALL_ON : ALL_OFF;

  logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
  logic [CUR_W-1:0]      cur_digit_q, cur_digit_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  first_q, first_d;
  logic [4*DIGITS-1:0]   shadow_dig_q, shadow_dig_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]     shadow_en_q, shadow_en_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [7:0]            pattern_q, pattern_d;

  logic                  slot_end;
  logic                  wrap;
  logic                  snap;
  logic                  pwm_on;
  logic                  blanked;
  logic                  dp_bit;
  logic                  lit;
  logic [3:0]            cur_nibble;
  logic [6:0]            dec_segs;
  logic [DIGITS-1:0]     lz_blank;
  logic [DIGITS-1:0]     an_act;
  logic [7:0]            pat_act;

  seg_hex_decoder u_dec (
    .nibble (cur_nibble),
    .segs   (dec_segs)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Walk down from the most significant digit; digit 0 is never blanked
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (shadow_dig_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end
`else
  always_comb begin
    lz_blank = '0;
  end
`endif

  always_comb begin
    slot_end    = &prescaler_q;
    wrap        = slot_end && (cur_digit_q == LAST_DIGIT);
    prescaler_d = prescaler_q + PRESCALE_W'(1);

    cur_digit_d = cur_digit_q;
    if (slot_end) begin
      cur_digit_d = wrap ? '0 : cur_digit_q + CUR_W'(1);
    end

    frame_tick_d = wrap;
    first_d      = 1'b0;

    snap         = wrap | first_q;
    shadow_dig_d = snap ? digits_in : shadow_dig_q;
    shadow_dp_d  = snap ? dp_in     : shadow_dp_q;
    shadow_en_d  = snap ? digit_en  : shadow_en_q;

    cur_nibble = shadow_dig_q[{cur_digit_q, 2'b00} +: 4];
    pwm_on     = (prescaler_q[PRESCALE_W-1 -: DIM_W] <= brightness);
    blanked    = lz_blank[cur_digit_q];
    dp_bit     = shadow_dp_q[cur_digit_q];

    // slot_end term gives the break-before-make dead cycle at each digit change
    lit = pwm_on & shadow_en_q[cur_digit_q] & ~slot_end & (~blanked | dp_bit);

    an_act  = '0;
    pat_act = ALL_OFF;
    if (lit) begin
      an_act                = DIGITS'(1) << cur_digit_q;
      pat_act[SEG_DP]       = dp_bit;
      pat_act[SEG_A:SEG_G]  = blanked ? 7'b0000000 : dec_segs;
    end

    an_d      = an_act ^ AN_MASK;
    pattern_d = pat_act ^ PAT_MASK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prescaler_q  <= '0;
      cur_digit_q  <= '0;
      frame_tick_q <= 1'b0;
      first_q      <= 1'b1;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      shadow_en_q  <= '0;
      an_q         <= AN_MASK;
      pattern_q    <= PAT_MASK;
    end else begin
      prescaler_q  <= prescaler_d;
      cur_digit_q  <= cur_digit_d;
      frame_tick_q <= frame_tick_d;
      first_q      <= first_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_en_q  <= shadow_en_d;
      an_q         <= an_d;
      pattern_q    <= pattern_d;
    end
  end

  assign an         = an_q;
  assign pattern    = pattern_q;
  assign cur_digit  = cur_digit_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
// ============================================================================
// Module   : tb_seg_scan_mux
// Purpose  : Self-checking bench for seg_scan_mux (4-digit and 3-digit builds)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  pattern;
  logic [1:0]  cur_digit;
  logic        frame_tick;

  logic [11:0] digits3;
  logic [2:0]  dp3;
  logic [2:0]  en3;
  logic [2:0]  an3;
  logic [7:0]  pattern3;
  logic [1:0]  cur3;
  logic        ft3;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          act_cnt[4];
  int          multi_cnt;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGITS(4), .PRESCALE_W(4), .DIM_W(2), .ACTIVE_LOW(1)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .brightness (brightness),
    .an         (an),
    .pattern    (pattern),
    .cur_digit  (cur_digit),
    .frame_tick (frame_tick)
  );

  seg_scan_mux #(.DIGITS(3), .PRESCALE_W(4), .DIM_W(2), .ACTIVE_LOW(1)) u_dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .digits_in  (digits3),
    .dp_in      (dp3),
    .digit_en   (en3),
    .brightness (brightness),
    .an         (an3),
    .pattern    (pattern3),
    .cur_digit  (cur3),
    .frame_tick (ft3)
  );

  function automatic logic [6:0] model_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hDEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({24'h0, ~{dp[k], model_seg(d[4*k +: 4])}});
    end
  endtask

  task automatic wait_ft();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = frame_tick;
    end
    check("frame_tick_seen", {31'h0, found}, 32'd1);
  endtask

  // Counts active-low an cycles per digit over one 64-cycle frame
  task automatic count_frame();
    for (int k = 0; k < 4; k++) act_cnt[k] = 0;
    multi_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      for (int k = 0; k < 4; k++) if (!an[k]) act_cnt[k]++;
      if ($countones(~an) > 1) multi_cnt++;
    end
  endtask

  task automatic check_counts(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_dig%0d", tag, k), act_cnt[k], pop_exp());
    end
    check({tag, "_onehot"}, multi_cnt, 32'd0);
  endtask

  task automatic check_frame_patterns(input string tag, input logic [15:0] new_digits,
                                      input logic change);
    logic [3:0] one;
    one = 4'b0001;
    step(); step(); step(); step(); step(); step(); step(); step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_cur%0d", tag, k), {30'h0, cur_digit}, k);
      check($sformatf("%s_an%0d", tag, k), {28'h0, an}, {28'h0, ~(one << k)});
      check($sformatf("%s_pat%0d", tag, k), {24'h0, pattern}, pop_exp());
      if (k == 0 && change) digits_in = new_digits;
      if (k < 3) repeat (16) step();
    end
  endtask

  initial begin
    logic [1:0] prev;
    int         ft_cnt;
    int         bad3;
    int         ch3;
    int         wraps3;

    reset_n    = 1'b0;
    digits_in  = 16'h1A80;
    dp_in      = 4'b0100;
    digit_en   = 4'hF;
    brightness = 2'd3;
    digits3    = 12'h123;
    dp3        = 3'b000;
    en3        = 3'b111;

    // Reset state
    repeat (5) step();
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_pattern", {24'h0, pattern}, 32'hFF);
    check("rst_cur", {30'h0, cur_digit}, 32'd0);
    check("rst_ft", {31'h0, frame_tick}, 32'd0);

    // Scan order and single wrap pulse
    reset_n = 1'b1;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    prev   = 2'd0;
    ft_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (frame_tick) begin
        ft_cnt++;
        check("ft_at_zero", {30'h0, cur_digit}, 32'd0);
      end
      if (cur_digit != prev) check("visit", {30'h0, cur_digit}, pop_exp());
      prev = cur_digit;
    end
    check("ft_count", ft_cnt, 32'd1);
    check("visits_left", exp_q.size(), 32'd0);

    // Decode and tear-free snapshot
    push_frame(16'h1A80, 4'b0100);
    check_frame_patterns("old", 16'h2345, 1'b1);
    wait_ft();
    push_frame(16'h2345, 4'b0100);
    check_frame_patterns("new", 16'h0000, 1'b0);
    wait_ft();

    // PWM duty
    brightness = 2'd0;
    repeat (4) exp_q.push_back(4);
    count_frame();
    check_counts("pwm_b0");
    brightness = 2'd3;
    repeat (4) exp_q.push_back(15);
    count_frame();
    check_counts("pwm_b3");

    // Per-digit enable, then reset mid-slot
    digit_en = 4'b1011;
    repeat (64) step();
    exp_q.push_back(15); exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(15);
    count_frame();
    check_counts("en1011");
    repeat (37) step();
    check("pre_rst_cur", {30'h0, cur_digit}, 32'd2);
    reset_n   = 1'b0;
    digits_in = 16'h0050;
    dp_in     = 4'b0000;
    digit_en  = 4'hF;
    step();
    reset_n = 1'b1;
    check("midrst_an", {28'h0, an}, 32'hF);
    check("midrst_cur", {30'h0, cur_digit}, 32'd0);
    check("midrst_pat", {24'h0, pattern}, 32'hFF);
    check("midrst_ft", {31'h0, frame_tick}, 32'd0);

    // Leading-zero handling
    wait_ft();
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    exp_q.push_back(15); exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(0);
`else
    repeat (4) exp_q.push_back(15);
`endif
    count_frame();
    check_counts("lz_0050");
    digits_in = 16'h0000;
    repeat (64) step();
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
`else
    repeat (4) exp_q.push_back(15);
`endif
    count_frame();
    check_counts("lz_0000");
    repeat (8) step();
    check("lz_d0_pat", {24'h0, pattern}, {24'h0, ~{1'b0, model_seg(4'h0)}});

    // Three-digit build: sequence 0,1,2,0 and never 3
    bad3   = 0;
    ch3    = 0;
    wraps3 = 0;
    prev   = cur3;
    for (int i = 0; i < 96; i++) begin
      step();
      if (cur3 > 2'd2) bad3++;
      if (ft3) wraps3++;
      if (cur3 != prev) begin
        ch3++;
        exp_q.push_back((prev == 2'd2) ? 32'd0 : {30'h0, prev} + 32'd1);
        check("d3_next", {30'h0, cur3}, pop_exp());
      end
      prev = cur3;
    end
    check("d3_range", bad3, 32'd0);
    check("d3_changes", ch3, 32'd6);
    check("d3_wraps", wraps3, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
